// File: rtl/ctrl_pkg.sv
// Shared constants for the pipelined control unit: opcodes, func codes, control-word bit
// positions and PC-select encodings.
package ctrl_pkg;

  localparam int unsigned CTRL_W = 12;

  // Control-word bit positions, MSB first
  localparam int unsigned C_MEM_TO_REG = 11;
  localparam int unsigned C_MEM_WRITE  = 10;
  localparam int unsigned C_ALU_SRC    = 9;
  localparam int unsigned C_REG_WRITE  = 8;
  localparam int unsigned C_SYSCALL    = 7;
  localparam int unsigned C_SIGNED_EXT = 6;
  localparam int unsigned C_REG_DST    = 5;
  localparam int unsigned C_BEQ        = 4;
  localparam int unsigned C_BNE        = 3;
  localparam int unsigned C_JR         = 2;
  localparam int unsigned C_JMP        = 1;
  localparam int unsigned C_JAL        = 0;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL     = 6'h00;
  localparam logic [5:0] FN_JR      = 6'h08;
  localparam logic [5:0] FN_SYSCALL = 6'h0C;
  localparam logic [5:0] FN_ADD     = 6'h20;
  localparam logic [5:0] FN_ADDU    = 6'h21;
  localparam logic [5:0] FN_SUB     = 6'h22;
  localparam logic [5:0] FN_AND     = 6'h24;
  localparam logic [5:0] FN_OR      = 6'h25;
  localparam logic [5:0] FN_SLT     = 6'h2A;

  typedef enum logic [1:0] {
    PcSeq    = 2'd0,
    PcJump   = 2'd1,
    PcRs     = 2'd2,
    PcBranch = 2'd3
  } pc_sel_e;

  typedef enum logic [1:0] {
    DstRt = 2'd0,
    DstRd = 2'd1,
    DstRa = 2'd2
  } dst_sel_e;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational op/func decoder: control word, destination select, illegal flag and
// which source registers the instruction actually reads.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [5:0]        op,
  input  logic [5:0]        func,
  output logic [CTRL_W-1:0] ctrl,
  output dst_sel_e          dst_sel,
  output logic              illegal,
  output logic              use_rs,
  output logic              use_rt
);

  always_comb begin
    ctrl    = '0;
    dst_sel = DstRt;
    illegal = 1'b0;
    use_rs  = 1'b0;
    use_rt  = 1'b0;
    case (op)
      OP_RTYPE: begin
        case (func)
          FN_ADD, FN_ADDU, FN_SUB, FN_AND, FN_OR, FN_SLT: begin
            ctrl[C_REG_WRITE] = 1'b1;
            ctrl[C_REG_DST]   = 1'b1;
            dst_sel           = DstRd;
            use_rs            = 1'b1;
            use_rt            = 1'b1;
          end
          // Shift amount comes from the instruction, so rs is not read
          FN_SLL: begin
            ctrl[C_REG_WRITE] = 1'b1;
            ctrl[C_REG_DST]   = 1'b1;
            dst_sel           = DstRd;
            use_rt            = 1'b1;
          end
          FN_JR: begin
            ctrl[C_JR] = 1'b1;
            use_rs     = 1'b1;
          end
          FN_SYSCALL: ctrl[C_SYSCALL] = 1'b1;
          default:    illegal = 1'b1;
        endcase
      end
      OP_ADDI, OP_ADDIU, OP_SLTI: begin
        ctrl[C_ALU_SRC]    = 1'b1;
        ctrl[C_REG_WRITE]  = 1'b1;
        ctrl[C_SIGNED_EXT] = 1'b1;
        use_rs             = 1'b1;
      end
      OP_ANDI, OP_ORI: begin
        ctrl[C_ALU_SRC]   = 1'b1;
        ctrl[C_REG_WRITE] = 1'b1;
        use_rs            = 1'b1;
      end
      OP_LW: begin
        ctrl[C_MEM_TO_REG] = 1'b1;
        ctrl[C_ALU_SRC]    = 1'b1;
        ctrl[C_REG_WRITE]  = 1'b1;
        ctrl[C_SIGNED_EXT] = 1'b1;
        use_rs             = 1'b1;
      end
      OP_SW: begin
        ctrl[C_MEM_WRITE]  = 1'b1;
        ctrl[C_ALU_SRC]    = 1'b1;
        ctrl[C_SIGNED_EXT] = 1'b1;
        use_rs             = 1'b1;
        use_rt             = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        ctrl[C_BEQ]        = (op == OP_BEQ);
        ctrl[C_BNE]        = (op == OP_BNE);
        ctrl[C_SIGNED_EXT] = 1'b1;
        use_rs             = 1'b1;
        use_rt             = 1'b1;
      end
      OP_J: ctrl[C_JMP] = 1'b1;
      OP_JAL: begin
        ctrl[C_JAL]       = 1'b1;
        ctrl[C_REG_WRITE] = 1'b1;
        dst_sel           = DstRa;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/ctrl_pipe_unit.sv
// Pipelined control unit: ID decode, ID/EX, EX/MEM, MEM/WB control registers, hazard
// detection, redirect and SYSCALL halt. Define CTRL_FORWARD_EN to enable forwarding.
module ctrl_pipe_unit #(
  parameter int unsigned REG_W  = 5,
  parameter int unsigned CTRL_W = ctrl_pkg::CTRL_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [5:0]        id_op,
  input  logic [5:0]        id_func,
  input  logic [REG_W-1:0]  id_rs,
  input  logic [REG_W-1:0]  id_rt,
  input  logic [REG_W-1:0]  id_rd,
  input  logic              ex_zero,
  output logic              id_stall,
  output logic              id_flush,
  output logic [1:0]        pc_sel,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [REG_W-1:0]  ex_dst,
  output logic [CTRL_W-1:0] mem_ctrl,
  output logic [REG_W-1:0]  mem_dst,
  output logic [CTRL_W-1:0] wb_ctrl,
  output logic [REG_W-1:0]  wb_dst,
  output logic              wb_valid,
  output logic              illegal,
  output logic              halted,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b
);
  import ctrl_pkg::*;

  logic [CTRL_W-1:0] dec_ctrl;
  dst_sel_e          dec_dst_sel;
  logic              dec_illegal, dec_use_rs, dec_use_rt;

  ctrl_decode u_decode (
    .op      (id_op),
    .func    (id_func),
    .ctrl    (dec_ctrl),
    .dst_sel (dec_dst_sel),
    .illegal (dec_illegal),
    .use_rs  (dec_use_rs),
    .use_rt  (dec_use_rt)
  );

  logic              ex_valid_q, mem_valid_q, wb_valid_q, halted_q;
  logic [CTRL_W-1:0] ex_ctrl_q, mem_ctrl_q, wb_ctrl_q;
  logic [REG_W-1:0]  ex_dst_q, mem_dst_q, wb_dst_q;
  logic              ex_valid_d;
  logic [CTRL_W-1:0] ex_ctrl_d;
  logic [REG_W-1:0]  ex_dst_d, id_dst;
  logic              halted_d;
  logic              id_use_rs, id_use_rt;
  logic              ex_wr, mem_wr, wb_wr;
  logic              taken, sys_inflight, raw_stall, issue;
  pc_sel_e           pc_sel_d;

  function automatic logic src_hit(input logic wr, input logic [REG_W-1:0] dst,
                                   input logic use_a, input logic [REG_W-1:0] a,
                                   input logic use_b, input logic [REG_W-1:0] b);
    return wr && (dst != '0) && ((use_a && (a == dst)) || (use_b && (b == dst)));
  endfunction

  always_comb begin
    case (dec_dst_sel)
      DstRd:   id_dst = id_rd;
      DstRa:   id_dst = '1;
      default: id_dst = id_rt;
    endcase
  end

  assign id_use_rs = id_valid & dec_use_rs;
  assign id_use_rt = id_valid & dec_use_rt;
  assign illegal   = id_valid & dec_illegal;

  assign ex_wr  = ex_valid_q & ex_ctrl_q[C_REG_WRITE];
  assign mem_wr = mem_valid_q & mem_ctrl_q[C_REG_WRITE];
  assign wb_wr  = wb_valid_q & wb_ctrl_q[C_REG_WRITE];

  assign taken = ex_valid_q & ((ex_ctrl_q[C_BEQ] & ex_zero) | (ex_ctrl_q[C_BNE] & ~ex_zero));

  // A SYSCALL anywhere past ID blocks issue until the halt flag takes over
  assign sys_inflight = (ex_valid_q & ex_ctrl_q[C_SYSCALL]) |
                        (mem_valid_q & mem_ctrl_q[C_SYSCALL]) |
                        (wb_valid_q & wb_ctrl_q[C_SYSCALL]);

`ifdef CTRL_FORWARD_EN
  logic             ex_use_rs_q, ex_use_rt_q;
  logic [REG_W-1:0] ex_rs_q, ex_rt_q;

  function automatic logic [1:0] fwd_sel(input logic use_src, input logic [REG_W-1:0] src);
    if (src_hit(mem_wr, mem_dst_q, use_src, src, 1'b0, src)) return 2'd2;
    if (src_hit(wb_wr, wb_dst_q, use_src, src, 1'b0, src))   return 2'd1;
    return 2'd0;
  endfunction

  // Only a load in EX cannot be forwarded in time
  assign raw_stall = src_hit(ex_wr & ex_ctrl_q[C_MEM_TO_REG], ex_dst_q,
                             id_use_rs, id_rs, id_use_rt, id_rt);
  assign fwd_a     = fwd_sel(ex_use_rs_q, ex_rs_q);
  assign fwd_b     = fwd_sel(ex_use_rt_q, ex_rt_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_use_rs_q <= 1'b0;
      ex_use_rt_q <= 1'b0;
      ex_rs_q     <= '0;
      ex_rt_q     <= '0;
    end else begin
      ex_use_rs_q <= issue & id_use_rs;
      ex_use_rt_q <= issue & id_use_rt;
      ex_rs_q     <= issue ? id_rs : '0;
      ex_rt_q     <= issue ? id_rt : '0;
    end
  end
`else
  assign raw_stall = src_hit(ex_wr, ex_dst_q, id_use_rs, id_rs, id_use_rt, id_rt) |
                     src_hit(mem_wr, mem_dst_q, id_use_rs, id_rs, id_use_rt, id_rt);
  assign fwd_a     = 2'd0;
  assign fwd_b     = 2'd0;
`endif

  // A taken branch squashes ID outright, so it overrides every stall source
  assign id_stall = ~taken & (halted_q | sys_inflight | raw_stall);
  assign issue    = id_valid & ~taken & ~id_stall;

  always_comb begin
    pc_sel_d = PcSeq;
    id_flush = 1'b0;
    if (taken) begin
      pc_sel_d = PcBranch;
      id_flush = 1'b1;
    end else if (issue && (dec_ctrl[C_JMP] || dec_ctrl[C_JAL])) begin
      pc_sel_d = PcJump;
      id_flush = 1'b1;
    end else if (issue && dec_ctrl[C_JR]) begin
      pc_sel_d = PcRs;
      id_flush = 1'b1;
    end
  end

  assign pc_sel = pc_sel_d;

  always_comb begin
    ex_valid_d = issue;
    ex_ctrl_d  = issue ? dec_ctrl : '0;
    ex_dst_d   = issue ? id_dst : '0;
    halted_d   = halted_q | (wb_valid_q & wb_ctrl_q[C_SYSCALL]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q  <= 1'b0;
      ex_ctrl_q   <= '0;
      ex_dst_q    <= '0;
      mem_valid_q <= 1'b0;
      mem_ctrl_q  <= '0;
      mem_dst_q   <= '0;
      wb_valid_q  <= 1'b0;
      wb_ctrl_q   <= '0;
      wb_dst_q    <= '0;
      halted_q    <= 1'b0;
    end else begin
      ex_valid_q  <= ex_valid_d;
      ex_ctrl_q   <= ex_ctrl_d;
      ex_dst_q    <= ex_dst_d;
      mem_valid_q <= ex_valid_q;
      mem_ctrl_q  <= ex_ctrl_q;
      mem_dst_q   <= ex_dst_q;
      wb_valid_q  <= mem_valid_q;
      wb_ctrl_q   <= mem_ctrl_q;
      wb_dst_q    <= mem_dst_q;
      halted_q    <= halted_d;
    end
  end

  assign ex_ctrl  = ex_ctrl_q;
  assign ex_dst   = ex_dst_q;
  assign mem_ctrl = mem_ctrl_q;
  assign mem_dst  = mem_dst_q;
  assign wb_ctrl  = wb_ctrl_q;
  assign wb_dst   = wb_dst_q;
  assign wb_valid = wb_valid_q;
  assign halted   = halted_q;

endmodule

// File: tb/tb_ctrl_pipe_unit.sv
// Directed bench for ctrl_pipe_unit; expectations follow CTRL_FORWARD_EN when defined.
module tb_ctrl_pipe_unit;

  logic        clk, rst_n, id_valid, ex_zero;
  logic [5:0]  id_op, id_func;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic        id_stall, id_flush, wb_valid, illegal, halted;
  logic [1:0]  pc_sel, fwd_a, fwd_b;
  logic [11:0] ex_ctrl, mem_ctrl, wb_ctrl;
  logic [4:0]  ex_dst, mem_dst, wb_dst;

  int n_tests = 0;
  int n_fail  = 0;

  ctrl_pipe_unit dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .id_valid (id_valid),
    .id_op    (id_op),
    .id_func  (id_func),
    .id_rs    (id_rs),
    .id_rt    (id_rt),
    .id_rd    (id_rd),
    .ex_zero  (ex_zero),
    .id_stall (id_stall),
    .id_flush (id_flush),
    .pc_sel   (pc_sel),
    .ex_ctrl  (ex_ctrl),
    .ex_dst   (ex_dst),
    .mem_ctrl (mem_ctrl),
    .mem_dst  (mem_dst),
    .wb_ctrl  (wb_ctrl),
    .wb_dst   (wb_dst),
    .wb_valid (wb_valid),
    .illegal  (illegal),
    .halted   (halted),
    .fwd_a    (fwd_a),
    .fwd_b    (fwd_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1);
  end

`ifdef CTRL_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [5:0] op, input logic [5:0] fn,
                       input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    id_valid = v;
    id_op    = op;
    id_func  = fn;
    id_rs    = rs;
    id_rt    = rt;
    id_rd    = rd;
  endtask

  task automatic drain();
    drive(1'b0, 6'h00, 6'h00, 5'd0, 5'd0, 5'd0);
    ex_zero = 1'b0;
    repeat (4) tick();
  endtask

  // Holds the current ID instruction until it issues; returns the stall cycles seen
  task automatic issue_held(output int stalls);
    stalls = 0;
    for (int i = 0; i < 8; i++) begin
      #2;
      if (!id_stall) break;
      stalls++;
      tick();
    end
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b0, 6'h00, 6'h00, 5'd0, 5'd0, 5'd0);
    ex_zero = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    n_tests++; if (ex_ctrl !== 12'h000) begin n_fail++; $display("FAIL reset_ex_ctrl: got %h want 000", ex_ctrl); end
    n_tests++; if (wb_ctrl !== 12'h000) begin n_fail++; $display("FAIL reset_wb_ctrl: got %h want 000", wb_ctrl); end
    n_tests++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL reset_wb_valid: got %b want 0", wb_valid); end
    n_tests++; if (halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted: got %b want 0", halted); end
    n_tests++; if (pc_sel !== 2'd0) begin n_fail++; $display("FAIL reset_pc_sel: got %0d want 0", pc_sel); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_raw();
    int stalls;
    drain();
    drive(1'b1, 6'h00, 6'h20, 5'd1, 5'd2, 5'd3);  // ADD $3,$1,$2
    tick();
    drive(1'b1, 6'h00, 6'h22, 5'd3, 5'd1, 5'd4);  // SUB $4,$3,$1
    issue_held(stalls);
    drive(1'b0, 6'h00, 6'h00, 5'd0, 5'd0, 5'd0);
    #2;
    n_tests++; if (stalls !== (FWD ? 0 : 2)) begin n_fail++; $display("FAIL raw_stalls: got %0d want %0d", stalls, FWD ? 0 : 2); end
    n_tests++; if (fwd_a !== (FWD ? 2'd2 : 2'd0)) begin n_fail++; $display("FAIL raw_fwd_a: got %0d want %0d", fwd_a, FWD ? 2 : 0); end
    n_tests++; if (fwd_b !== 2'd0) begin n_fail++; $display("FAIL raw_fwd_b: got %0d want 0", fwd_b); end
    n_tests++; if (ex_ctrl !== 12'h120) begin n_fail++; $display("FAIL raw_ex_ctrl: got %h want 120", ex_ctrl); end
    n_tests++; if (ex_dst !== 5'd4) begin n_fail++; $display("FAIL raw_ex_dst: got %0d want 4", ex_dst); end
  endtask

  task automatic test_load_use();
    int stalls;
    drain();
    drive(1'b1, 6'h23, 6'h00, 5'd1, 5'd5, 5'd0);  // LW $5,0($1)
    tick();
    drive(1'b1, 6'h00, 6'h20, 5'd5, 5'd5, 5'd6);  // ADD $6,$5,$5
    #2;
    n_tests++; if (ex_ctrl !== 12'hB40) begin n_fail++; $display("FAIL lw_ex_ctrl: got %h want b40", ex_ctrl); end
    n_tests++; if (ex_dst !== 5'd5) begin n_fail++; $display("FAIL lw_ex_dst: got %0d want 5", ex_dst); end
    issue_held(stalls);
    drive(1'b0, 6'h00, 6'h00, 5'd0, 5'd0, 5'd0);
    #2;
    n_tests++; if (stalls !== (FWD ? 1 : 2)) begin n_fail++; $display("FAIL lu_stalls: got %0d want %0d", stalls, FWD ? 1 : 2); end
    n_tests++; if (fwd_a !== (FWD ? 2'd1 : 2'd0)) begin n_fail++; $display("FAIL lu_fwd_a: got %0d want %0d", fwd_a, FWD ? 1 : 0); end
    n_tests++; if (fwd_b !== (FWD ? 2'd1 : 2'd0)) begin n_fail++; $display("FAIL lu_fwd_b: got %0d want %0d", fwd_b, FWD ? 1 : 0); end
  endtask

  task automatic test_branch_squash();
    int bad;
    drain();
    ex_zero = 1'b1;
    drive(1'b1, 6'h04, 6'h00, 5'd1, 5'd2, 5'd0);  // BEQ $1,$2
    tick();
    drive(1'b1, 6'h03, 6'h00, 5'd0, 5'd0, 5'd0);  // JAL
    #2;
    n_tests++; if (pc_sel !== 2'd3) begin n_fail++; $display("FAIL br_pc_sel: got %0d want 3", pc_sel); end
    n_tests++; if (id_flush !== 1'b1) begin n_fail++; $display("FAIL br_flush: got %b want 1", id_flush); end
    n_tests++; if (id_stall !== 1'b0) begin n_fail++; $display("FAIL br_stall: got %b want 0", id_stall); end
    tick();
    drive(1'b0, 6'h00, 6'h00, 5'd0, 5'd0, 5'd0);
    ex_zero = 1'b0;
    #2;
    n_tests++; if (ex_ctrl !== 12'h000) begin n_fail++; $display("FAIL br_squash_ex: got %h want 000", ex_ctrl); end
    tick();
    #2;
    n_tests++; if (wb_valid !== 1'b1 || wb_ctrl[4] !== 1'b1) begin n_fail++; $display("FAIL br_retire: got valid=%b ctrl=%h want valid=1 beq=1", wb_valid, wb_ctrl); end
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      if (wb_valid && wb_dst == 5'd31) bad++;
      tick();
      #2;
    end
    n_tests++; if (bad !== 0) begin n_fail++; $display("FAIL br_no_ra_retire: got %0d want 0", bad); end
  endtask

  task automatic test_jump();
    drain();
    drive(1'b1, 6'h03, 6'h00, 5'd0, 5'd0, 5'd0);  // JAL
    #2;
    n_tests++; if (pc_sel !== 2'd1) begin n_fail++; $display("FAIL jal_pc_sel: got %0d want 1", pc_sel); end
    n_tests++; if (id_flush !== 1'b1) begin n_fail++; $display("FAIL jal_flush: got %b want 1", id_flush); end
    tick();
    drive(1'b0, 6'h00, 6'h00, 5'd0, 5'd0, 5'd0);
    tick();
    tick();
    #2;
    n_tests++; if (wb_valid !== 1'b1 || wb_dst !== 5'd31) begin n_fail++; $display("FAIL jal_wb_dst: got valid=%b dst=%0d want valid=1 dst=31", wb_valid, wb_dst); end
    n_tests++; if (wb_ctrl[8] !== 1'b1) begin n_fail++; $display("FAIL jal_wb_regwrite: got %b want 1", wb_ctrl[8]); end
    drain();
    drive(1'b1, 6'h00, 6'h08, 5'd7, 5'd0, 5'd0);  // JR $7
    #2;
    n_tests++; if (pc_sel !== 2'd2 || id_flush !== 1'b1) begin n_fail++; $display("FAIL jr_redirect: got pc_sel=%0d flush=%b want 2,1", pc_sel, id_flush); end
    tick();
    drive(1'b1, 6'h00, 6'h20, 5'd1, 5'd2, 5'd3);  // ADD $3,$1,$2
    tick();
    drive(1'b1, 6'h00, 6'h08, 5'd3, 5'd0, 5'd0);  // JR $3 right behind its producer
    #2;
    n_tests++; if (id_stall !== !FWD) begin n_fail++; $display("FAIL jr_hazard_stall: got %b want %b", id_stall, !FWD); end
    n_tests++; if (pc_sel !== (FWD ? 2'd2 : 2'd0)) begin n_fail++; $display("FAIL jr_hazard_pc_sel: got %0d want %0d", pc_sel, FWD ? 2 : 0); end
    drive(1'b0, 6'h00, 6'h00, 5'd0, 5'd0, 5'd0);
  endtask

  task automatic test_illegal();
    drain();
    drive(1'b1, 6'h3F, 6'h00, 5'd1, 5'd2, 5'd3);
    #2;
    n_tests++; if (illegal !== 1'b1) begin n_fail++; $display("FAIL illegal_flag: got %b want 1", illegal); end
    tick();
    drive(1'b0, 6'h3F, 6'h00, 5'd1, 5'd2, 5'd3);
    #2;
    n_tests++; if (ex_ctrl !== 12'h000) begin n_fail++; $display("FAIL illegal_ctrl: got %h want 000", ex_ctrl); end
    n_tests++; if (illegal !== 1'b0) begin n_fail++; $display("FAIL illegal_gated: got %b want 0", illegal); end
  endtask

  task automatic test_syscall();
    int stalls, bad;
    drain();
    drive(1'b1, 6'h00, 6'h0C, 5'd0, 5'd0, 5'd0);  // SYSCALL
    #2;
    n_tests++; if (id_stall !== 1'b0) begin n_fail++; $display("FAIL sys_issue_stall: got %b want 0", id_stall); end
    tick();
    drive(1'b1, 6'h00, 6'h20, 5'd1, 5'd2, 5'd9);  // ADD $9 waiting behind it
    stalls = 0;
    for (int i = 0; i < 3; i++) begin
      #2;
      if (id_stall) stalls++;
      tick();
    end
    n_tests++; if (stalls !== 3) begin n_fail++; $display("FAIL sys_drain_stall: got %0d want 3", stalls); end
    #2;
    n_tests++; if (halted !== 1'b1) begin n_fail++; $display("FAIL sys_halted: got %b want 1", halted); end
    drive(1'b1, 6'h03, 6'h00, 5'd0, 5'd0, 5'd0);  // JAL must not redirect once halted
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (wb_valid || !id_stall || pc_sel != 2'd0 || !halted) bad++;
      tick();
      #2;
    end
    n_tests++; if (bad !== 0) begin n_fail++; $display("FAIL sys_hold: got %0d bad cycles want 0", bad); end
  endtask

  task automatic test_reset_mid();
    rst_n = 1'b0;
    #2;
    n_tests++; if (halted !== 1'b0) begin n_fail++; $display("FAIL rst_halt_clear: got %b want 0", halted); end
    tick();
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 6'h00, 6'h20, 5'd1, 5'd2, 5'(10 + i));
      tick();
    end
    drive(1'b1, 6'h00, 6'h20, 5'd1, 5'd2, 5'd13);
    #2;
    n_tests++; if (wb_valid !== 1'b1 || wb_dst !== 5'd10) begin n_fail++; $display("FAIL mid_pre_wb: got valid=%b dst=%0d want 1,10", wb_valid, wb_dst); end
    rst_n = 1'b0;
    drive(1'b0, 6'h00, 6'h00, 5'd0, 5'd0, 5'd0);
    #1;
    n_tests++; if (ex_ctrl !== 12'h000 || mem_ctrl !== 12'h000 || wb_ctrl !== 12'h000) begin n_fail++; $display("FAIL mid_ctrl: got %h %h %h want 000", ex_ctrl, mem_ctrl, wb_ctrl); end
    n_tests++; if (wb_valid !== 1'b0 || halted !== 1'b0 || pc_sel !== 2'd0) begin n_fail++; $display("FAIL mid_state: got wbv=%b halted=%b pc_sel=%0d want 0,0,0", wb_valid, halted, pc_sel); end
    n_tests++; if (ex_dst !== 5'd0 || wb_dst !== 5'd0) begin n_fail++; $display("FAIL mid_dst: got %0d %0d want 0 0", ex_dst, wb_dst); end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_raw();
    test_load_use();
    test_branch_squash();
    test_jump();
    test_illegal();
    test_syscall();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
